// File: rtl/edge_raster_block.sv
`default_nettype none
// ============================================================================
// Module      : edge_raster_block
// Description : Rasterises the three edges of a triangle into a 64x64 edge
//               bitmap using integer Bresenham, one pixel per clock.
//               Optional macro RASTER_CLIP_EN: rasterise oversized triangles
//               with clipping instead of skipping them.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_raster_block #(
    parameter int COORD_BITS = 8,
    parameter int GRID_DIM   = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [6*COORD_BITS-1:0]      coordinates,
    input  logic                         math_start,
    output logic                         busy,
    output logic                         raster_done,
    output logic                         range_err,
    output logic [COORD_BITS-1:0]        origin_x,
    output logic [COORD_BITS-1:0]        origin_y,
    output logic [GRID_DIM*GRID_DIM-1:0] line_buffer
);

    localparam int c_SW = COORD_BITS + 2;
    localparam int c_GW = $clog2(GRID_DIM);
`ifdef RASTER_CLIP_EN
    localparam bit c_CLIP = 1'b1;
`else
    localparam bit c_CLIP = 1'b0;
`endif

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SETUP     = 3'd1;
    localparam logic [2:0] c_ST_EDGE_INIT = 3'd2;
    localparam logic [2:0] c_ST_PLOT      = 3'd3;
    localparam logic [2:0] c_ST_DONE      = 3'd4;

    logic [2:0]                   r_state;
    logic [2:0]                   w_state_nx;
    logic [6*COORD_BITS-1:0]      r_coords;
    logic [COORD_BITS-1:0]        w_vx [3];
    logic [COORD_BITS-1:0]        w_vy [3];
    logic [COORD_BITS-1:0]        w_xmin, w_xmax, w_ymin, w_ymax;
    logic [COORD_BITS-1:0]        w_span_x, w_span_y;
    logic                         w_oversize;
    logic signed [c_SW-1:0]       r_rx [3];
    logic signed [c_SW-1:0]       r_ry [3];
    logic [1:0]                   r_edge, w_b_idx;
    logic signed [c_SW-1:0]       w_ddx, w_ddy, w_adx, w_ady, w_len;
    logic signed [c_SW-1:0]       r_x, r_y, r_dx, r_dy, r_err, r_cnt;
    logic                         r_sx_neg, r_sy_neg;
    logic signed [c_SW:0]         w_e2;
    logic                         w_step_x, w_step_y, w_in_grid, w_last;
    logic signed [c_SW-1:0]       w_err_nx;
    logic                         r_range_err;
    logic [COORD_BITS-1:0]        r_origin_x, r_origin_y;
    logic [GRID_DIM*GRID_DIM-1:0] r_line_buffer;

    assign range_err   = r_range_err;
    assign origin_x    = r_origin_x;
    assign origin_y    = r_origin_y;
    assign line_buffer = r_line_buffer;

    // Bounding box over the latched vertices
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_vx[k] = r_coords[2*k*COORD_BITS +: COORD_BITS];
            w_vy[k] = r_coords[(2*k+1)*COORD_BITS +: COORD_BITS];
        end
        w_xmin = w_vx[0];
        w_xmax = w_vx[0];
        w_ymin = w_vy[0];
        w_ymax = w_vy[0];
        for (int k = 1; k < 3; k++) begin
            if (w_vx[k] < w_xmin) w_xmin = w_vx[k];
            if (w_vx[k] > w_xmax) w_xmax = w_vx[k];
            if (w_vy[k] < w_ymin) w_ymin = w_vy[k];
            if (w_vy[k] > w_ymax) w_ymax = w_vy[k];
        end
        w_span_x   = w_xmax - w_xmin;
        w_span_y   = w_ymax - w_ymin;
        w_oversize = (w_span_x > COORD_BITS'(GRID_DIM-1)) ||
                     (w_span_y > COORD_BITS'(GRID_DIM-1));
    end

    always_comb begin
        w_b_idx  = (r_edge == 2'd2) ? 2'd0 : r_edge + 2'd1;
        w_ddx    = r_rx[w_b_idx] - r_rx[r_edge];
        w_ddy    = r_ry[w_b_idx] - r_ry[r_edge];
        w_adx    = w_ddx[c_SW-1] ? -w_ddx : w_ddx;
        w_ady    = w_ddy[c_SW-1] ? -w_ddy : w_ddy;
        w_len    = ((w_adx > w_ady) ? w_adx : w_ady) + c_SW'(1);
        w_e2     = {r_err, 1'b0};
        w_step_x = (w_e2 >= $signed({r_dy[c_SW-1], r_dy}));
        w_step_y = (w_e2 <= $signed({r_dx[c_SW-1], r_dx}));
        w_err_nx = r_err;
        if (w_step_x) w_err_nx = w_err_nx + r_dy;
        if (w_step_y) w_err_nx = w_err_nx + r_dx;
        // Upper bits clear means the pixel lies in 0..GRID_DIM-1 on that axis
        w_in_grid = (r_x[c_SW-1:c_GW] == '0) && (r_y[c_SW-1:c_GW] == '0);
        w_last    = (r_cnt == c_SW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        busy        = 1'b0;
        raster_done = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (math_start) w_state_nx = c_ST_SETUP;
            end
            c_ST_SETUP: begin
                busy       = 1'b1;
                w_state_nx = (w_oversize && !c_CLIP) ? c_ST_DONE : c_ST_EDGE_INIT;
            end
            c_ST_EDGE_INIT: begin
                busy       = 1'b1;
                w_state_nx = c_ST_PLOT;
            end
            c_ST_PLOT: begin
                busy = 1'b1;
                if (w_last) w_state_nx = (r_edge == 2'd2) ? c_ST_DONE : c_ST_EDGE_INIT;
            end
            c_ST_DONE: begin
                raster_done = 1'b1;
                if (math_start) w_state_nx = c_ST_SETUP;
            end
            default: w_state_nx = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_coords      <= '0;
            r_range_err   <= 1'b0;
            r_origin_x    <= '0;
            r_origin_y    <= '0;
            r_line_buffer <= '0;
            r_edge        <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_dx          <= '0;
            r_dy          <= '0;
            r_err         <= '0;
            r_cnt         <= '0;
            r_sx_neg      <= 1'b0;
            r_sy_neg      <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                r_rx[k] <= '0;
                r_ry[k] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (math_start) begin
                        r_coords      <= coordinates;
                        r_line_buffer <= '0;
                        r_range_err   <= 1'b0;
                        r_edge        <= '0;
                    end
                end
                c_ST_SETUP: begin
                    r_origin_x  <= w_xmin;
                    r_origin_y  <= w_ymin;
                    r_range_err <= w_oversize;
                    for (int k = 0; k < 3; k++) begin
                        r_rx[k] <= $signed({2'b00, w_vx[k] - w_xmin});
                        r_ry[k] <= $signed({2'b00, w_vy[k] - w_ymin});
                    end
                end
                c_ST_EDGE_INIT: begin
                    r_x      <= r_rx[r_edge];
                    r_y      <= r_ry[r_edge];
                    r_dx     <= w_adx;
                    r_dy     <= -w_ady;
                    r_err    <= w_adx - w_ady;
                    r_sx_neg <= w_ddx[c_SW-1];
                    r_sy_neg <= w_ddy[c_SW-1];
                    r_cnt    <= w_len;
                end
                c_ST_PLOT: begin
                    if (w_in_grid) r_line_buffer[{r_y[c_GW-1:0], r_x[c_GW-1:0]}] <= 1'b1;
                    if (w_step_x) r_x <= r_sx_neg ? r_x - c_SW'(1) : r_x + c_SW'(1);
                    if (w_step_y) r_y <= r_sy_neg ? r_y - c_SW'(1) : r_y + c_SW'(1);
                    r_err <= w_err_nx;
                    r_cnt <= r_cnt - c_SW'(1);
                    if (w_last) r_edge <= r_edge + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_raster_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_raster_block
// Description : Self-checking bench for edge_raster_block against a
//               pixel-walking reference model (honours RASTER_CLIP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_raster_block;

`ifdef RASTER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [47:0]   coordinates = '0;
    logic          math_start = 1'b0;
    logic          busy, raster_done, range_err;
    logic [7:0]    origin_x, origin_y;
    logic [4095:0] line_buffer;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    edge_raster_block #(.COORD_BITS(8), .GRID_DIM(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .coordinates (coordinates),
        .math_start  (math_start),
        .busy        (busy),
        .raster_done (raster_done),
        .range_err   (range_err),
        .origin_x    (origin_x),
        .origin_y    (origin_y),
        .line_buffer (line_buffer)
    );

    function automatic logic [47:0] pack(input int x0, input int y0, input int x1,
                                         input int y1, input int x2, input int y2);
        return {8'(y2), 8'(x2), 8'(y1), 8'(x1), 8'(y0), 8'(x0)};
    endfunction

    function automatic int first_diff(input logic [4095:0] a, input logic [4095:0] b);
        for (int i = 0; i < 4096; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    // Walks each edge pixel by pixel until the endpoint is reached.
    task automatic model(input logic [47:0] c, output logic [4095:0] bm, output int lat,
                         output bit rerr, output int ox, output int oy);
        int vx[3], vy[3];
        int xmin, xmax, ymin, ymax;
        int ax, ay, bx, by, x, y, dx, dy, sx, sy, err, e2, n;
        for (int k = 0; k < 3; k++) begin
            vx[k] = int'(c[16*k +: 8]);
            vy[k] = int'(c[16*k+8 +: 8]);
        end
        xmin = vx[0]; xmax = vx[0]; ymin = vy[0]; ymax = vy[0];
        for (int k = 1; k < 3; k++) begin
            if (vx[k] < xmin) xmin = vx[k];
            if (vx[k] > xmax) xmax = vx[k];
            if (vy[k] < ymin) ymin = vy[k];
            if (vy[k] > ymax) ymax = vy[k];
        end
        ox   = xmin;
        oy   = ymin;
        rerr = (xmax - xmin > 63) || (ymax - ymin > 63);
        bm   = '0;
        lat  = 2;
        if (rerr && !CLIP) return;
        for (int e = 0; e < 3; e++) begin
            ax = vx[e] - xmin;         ay = vy[e] - ymin;
            bx = vx[(e+1)%3] - xmin;   by = vy[(e+1)%3] - ymin;
            x = ax; y = ay;
            dx = (bx > ax) ? bx - ax : ax - bx;
            dy = -((by > ay) ? by - ay : ay - by);
            sx = (bx >= ax) ? 1 : -1;
            sy = (by >= ay) ? 1 : -1;
            err = dx + dy;
            n = 0;
            while (1) begin
                if (x >= 0 && x < 64 && y >= 0 && y < 64) bm[y*64 + x] = 1'b1;
                n++;
                if ((x == bx && y == by) || n > 600) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
            lat += 1 + n;
        end
    endtask

    task automatic start_job(input logic [47:0] c);
        @(negedge clk);
        coordinates = c;
        math_start  = 1'b1;
        @(posedge clk);
        #1;
        math_start  = 1'b0;
    endtask

    // cyc enters holding the current cycle number and leaves at the first DONE cycle
    task automatic wait_done(inout int cyc, output bit timeout);
        while (!raster_done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        timeout = !raster_done;
    endtask

    task automatic test_reset;
        logic [4095:0] bm;
        int lat, ox, oy, cyc;
        bit re;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || raster_done !== 1'b0 || range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b done=%b err=%b, expected 0 0 0", busy, raster_done, range_err);
        end
        n_checks++;
        if (line_buffer !== '0 || origin_x !== 8'd0 || origin_y !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d bits, origin (%0d,%0d), expected 0 bits, (0,0)",
                     $countones(line_buffer), origin_x, origin_y);
        end
        @(negedge clk);
        rst = 1'b0;
        model(pack(7, 9, 70, 9, 7, 72), bm, lat, re, ox, oy);
        start_job(pack(7, 9, 70, 9, 7, 72));
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || line_buffer === '0) begin
            n_fail++;
            $display("FAIL midplot_active: got busy=%b bits=%0d, expected busy=1 bits>0", busy, $countones(line_buffer));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || raster_done !== 1'b0 || line_buffer !== '0 ||
            origin_x !== 8'd0 || origin_y !== 8'd0 || range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midplot_reset: got busy=%b done=%b bits=%0d origin=(%0d,%0d), expected all zero",
                     busy, raster_done, $countones(line_buffer), origin_x, origin_y);
        end
        repeat (3) @(posedge clk);
        #1;
        cyc = 0;
        n_checks++;
        if (busy !== 1'b0 || raster_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0 (cyc %0d, model lat %0d)", busy, raster_done, cyc, lat);
        end
    endtask

    task automatic run_table(input string tag, input logic [47:0] jobs[$]);
        logic [4095:0] bm;
        int lat, ox, oy, cyc;
        bit re, to;
        foreach (jobs[j]) begin
            model(jobs[j], bm, lat, re, ox, oy);
            start_job(jobs[j]);
            cyc = 1;
            n_checks++;
            if (busy !== 1'b1 || raster_done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s[%0d] accept: got busy=%b done=%b, expected 1 0", tag, j, busy, raster_done);
            end
            wait_done(cyc, to);
            n_checks++;
            if (to) begin
                n_fail++;
                $display("FAIL %s[%0d] timeout: raster_done never rose, expected cycle %0d", tag, j, lat);
            end
            n_checks++;
            if (cyc !== lat) begin
                n_fail++;
                $display("FAIL %s[%0d] latency: got cycle %0d, expected %0d", tag, j, cyc, lat);
            end
            n_checks++;
            if (range_err !== re || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s[%0d] flags: got range_err=%b busy=%b, expected %b 0", tag, j, range_err, busy, re);
            end
            n_checks++;
            if (origin_x !== 8'(ox) || origin_y !== 8'(oy)) begin
                n_fail++;
                $display("FAIL %s[%0d] origin: got (%0d,%0d), expected (%0d,%0d)", tag, j, origin_x, origin_y, ox, oy);
            end
            n_checks++;
            if (line_buffer !== bm) begin
                n_fail++;
                $display("FAIL %s[%0d] bitmap: got %0d bits set, expected %0d, first diff bit %0d",
                         tag, j, $countones(line_buffer), $countones(bm), first_diff(line_buffer, bm));
            end
        end
    endtask

    task automatic test_shapes;
        logic [47:0] jobs[$];
        jobs.push_back(pack(10, 20, 10, 20, 10, 20));
        jobs.push_back(pack(5, 5, 12, 5, 5, 12));
        jobs.push_back(pack(0, 0, 100, 0, 0, 10));
        jobs.push_back(pack(200, 255, 137, 192, 255, 200));
        jobs.push_back(pack(30, 40, 30, 40, 60, 41));
        run_table("shape", jobs);
    endtask

    task automatic test_random;
        logic [47:0] jobs[$];
        int x[3], y[3], bx, by;
        for (int t = 0; t < 14; t++) begin
            bx = $urandom_range(0, 192);
            by = $urandom_range(0, 192);
            for (int k = 0; k < 3; k++) begin
                x[k] = (t % 4 == 3) ? $urandom_range(0, 255) : bx + $urandom_range(0, 63);
                y[k] = (t % 4 == 3) ? $urandom_range(0, 255) : by + $urandom_range(0, 63);
            end
            jobs.push_back(pack(x[0], y[0], x[1], y[1], x[2], y[2]));
        end
        run_table("random", jobs);
    endtask

    task automatic test_back_to_back;
        logic [47:0] c1, c2;
        logic [4095:0] bm1, bm2;
        int lat1, lat2, ox, oy, cyc;
        bit re, to;
        c1 = pack(3, 4, 40, 9, 17, 50);
        c2 = pack(60, 60, 70, 66, 62, 100);
        model(c1, bm1, lat1, re, ox, oy);
        model(c2, bm2, lat2, re, ox, oy);
        start_job(c1);
        cyc = 1;
        repeat (2) begin @(posedge clk); #1; cyc++; end
        start_job(c2);
        cyc++;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ignored_busy: got busy=%b, expected 1", busy);
        end
        wait_done(cyc, to);
        n_checks++;
        if (to || cyc !== lat1) begin
            n_fail++;
            $display("FAIL b2b_first_latency: got cycle %0d (timeout=%b), expected %0d", cyc, to, lat1);
        end
        n_checks++;
        if (line_buffer !== bm1) begin
            n_fail++;
            $display("FAIL b2b_first_bitmap: got %0d bits set, expected %0d, first diff bit %0d",
                     $countones(line_buffer), $countones(bm1), first_diff(line_buffer, bm1));
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (raster_done !== 1'b1 || line_buffer !== bm1 || origin_x !== 8'd3 || origin_y !== 8'd4) begin
            n_fail++;
            $display("FAIL done_hold: got done=%b bits=%0d origin=(%0d,%0d), expected 1 %0d (3,4)",
                     raster_done, $countones(line_buffer), origin_x, origin_y, $countones(bm1));
        end
        start_job(c2);
        cyc = 1;
        n_checks++;
        if (line_buffer !== '0 || raster_done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_clear: got bits=%0d done=%b busy=%b, expected 0 0 1",
                     $countones(line_buffer), raster_done, busy);
        end
        wait_done(cyc, to);
        n_checks++;
        if (to || cyc !== lat2) begin
            n_fail++;
            $display("FAIL b2b_second_latency: got cycle %0d (timeout=%b), expected %0d", cyc, to, lat2);
        end
        n_checks++;
        if (line_buffer !== bm2 || range_err !== re) begin
            n_fail++;
            $display("FAIL b2b_second_result: got %0d bits err=%b, expected %0d bits err=%b, first diff bit %0d",
                     $countones(line_buffer), range_err, $countones(bm2), re, first_diff(line_buffer, bm2));
        end
    endtask

    initial begin
        test_reset();
        test_shapes();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
